regfile_scoreboard: RTL and testbench

//  Parametrised successor to the pipeline register file: NUM_REGS x DATA_W storage with two

---
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 tb/tb_regfile_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port and a per-register
// in-flight write scoreboard for RAW hazard detection. Optional write-through: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_full,
  input  logic              writeBackEn,
  input  logic [ADDR_W-1:0] dest_wb,
  input  logic [DATA_W-1:0] Result_WB,
  output logic              sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [CNT_W-1:0]  pend_cnt [NUM_REGS];

  logic [ADDR_W-1:0] src_a [2];
  logic [DATA_W-1:0] rd_a  [2];
  logic              hz_a  [2];
  logic [CNT_W-1:0]  cnt_a [2];
  logic              hit_a [2];

  logic wb_ok;
  logic issue_ok;
  logic issue_ovf;
  logic wb_underflow;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign src_a[0] = src1;
  assign src_a[1] = src2;
  assign reg1     = rd_a[0];
  assign reg2     = rd_a[1];
  assign hazard1  = hz_a[0];
  assign hazard2  = hz_a[1];

  assign wb_ok      = writeBackEn && in_range(dest_wb);
  assign issue_full = in_range(issue_dest) && (pend_cnt[issue_dest] == CNT_MAX);
  assign issue_ok   = issue_en && !issue_full && in_range(issue_dest);
  assign issue_ovf  = issue_en && issue_full;
  // A retire with nothing outstanding is a sequencing bug upstream; the data still lands.
  assign wb_underflow = wb_ok && (pend_cnt[dest_wb] == '0);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_a[p]  = '0;
      cnt_a[p] = '0;
      hit_a[p] = 1'b0;
      hz_a[p]  = 1'b0;
      if (in_range(src_a[p])) begin
        rd_a[p]  = regs[src_a[p]];
        cnt_a[p] = pend_cnt[src_a[p]];
      end
      hit_a[p] = wb_ok && (dest_wb == src_a[p]);
      hz_a[p]  = (cnt_a[p] != '0);
`ifdef REGFILE_BYPASS_EN
      if (hit_a[p]) begin
        rd_a[p] = Result_WB;
        if (cnt_a[p] == CNT_W'(1)) hz_a[p] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]     <= DATA_W'(i);
        pend_cnt[i] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_ok) regs[dest_wb] <= Result_WB;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue_ok && (issue_dest == ADDR_W'(r)) && !(wb_ok && (dest_wb == ADDR_W'(r))))
          pend_cnt[r] <= pend_cnt[r] + CNT_W'(1);
        else if (wb_ok && (dest_wb == ADDR_W'(r)) && !(issue_ok && (issue_dest == ADDR_W'(r)))
                 && (pend_cnt[r] != '0))
          pend_cnt[r] <= pend_cnt[r] - CNT_W'(1);
      end
      if (issue_ovf || wb_underflow) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model. Honours REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
  localparam int DW = 32, AW = 4, NR = 16, CW = 2;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] src1, src2, issue_dest, dest_wb;
  logic [DW-1:0] reg1, reg2, Result_WB;
  logic          hazard1, hazard2, issue_en, issue_full, writeBackEn, sb_err;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
    .hazard1(hazard1), .hazard2(hazard2), .issue_en(issue_en), .issue_dest(issue_dest),
    .issue_full(issue_full), .writeBackEn(writeBackEn), .dest_wb(dest_wb),
    .Result_WB(Result_WB), .sb_err(sb_err)
  );

  logic [DW-1:0] m_reg [NR];
  int            m_cnt [NR];
  bit            m_err;
  int            n_chk = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] s);
    logic [DW-1:0] v;
    v = m_reg[s];
`ifdef REGFILE_BYPASS_EN
    if (writeBackEn && dest_wb == s) v = Result_WB;
`endif
    return v;
  endfunction

  function automatic logic exp_hz(input logic [AW-1:0] s);
    logic h;
    h = m_cnt[s] != 0;
`ifdef REGFILE_BYPASS_EN
    if (writeBackEn && dest_wb == s && m_cnt[s] == 1) h = 1'b0;
`endif
    return h;
  endfunction

  // Apply inputs mid-cycle and check every combinational output against the model.
  task automatic drive(input bit r, input bit ie, input logic [AW-1:0] idst, input bit we,
                       input logic [AW-1:0] dwb, input logic [DW-1:0] d,
                       input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    rst = r; issue_en = ie; issue_dest = idst; writeBackEn = we; dest_wb = dwb;
    Result_WB = d; src1 = s1; src2 = s2;
    #1;
    check_val("reg1", reg1, exp_rd(s1));
    check_val("reg2", reg2, exp_rd(s2));
    check_val("hazard1", DW'(hazard1), DW'(exp_hz(s1)));
    check_val("hazard2", DW'(hazard2), DW'(exp_hz(s2)));
    check_val("issue_full", DW'(issue_full), DW'(m_cnt[idst] == MAXC));
    check_val("sb_err", DW'(sb_err), DW'(m_err));
  endtask

  task automatic tick();
    bit full, inc_ok;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_reg[i] = DW'(i); m_cnt[i] = 0; end
      m_err = 1'b0;
    end else begin
      full   = m_cnt[issue_dest] == MAXC;
      inc_ok = issue_en && !full;
      if (issue_en && full) m_err = 1'b1;
      if (writeBackEn && m_cnt[dest_wb] == 0) m_err = 1'b1;
      if (inc_ok && !(writeBackEn && dest_wb == issue_dest)) m_cnt[issue_dest]++;
      if (writeBackEn && !(inc_ok && dest_wb == issue_dest) && m_cnt[dest_wb] > 0)
        m_cnt[dest_wb]--;
      if (writeBackEn) m_reg[dest_wb] = Result_WB;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    drive(0, 0, 4'd0, 0, 4'd0, '0, s1, s2);
  endtask

  function automatic logic [AW-1:0] pick_pending();
    int st;
    st = $urandom_range(0, NR-1);
    for (int k = 0; k < NR; k++)
      if (m_cnt[(st + k) % NR] > 0) return AW'((st + k) % NR);
    return AW'(st);
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) begin m_reg[i] = 'x; m_cnt[i] = 0; end
    m_err = 1'b0;
    rst = 1'b1; issue_en = 0; issue_dest = 0; writeBackEn = 0; dest_wb = 0;
    Result_WB = 0; src1 = 0; src2 = 0;
    @(negedge clk);

    // Reset and initial contents
    rst = 1'b1; tick();
    idle(4'd5, 4'd14);
    check_val("t1_reg1", reg1, 32'd5);
    check_val("t1_reg2", reg2, 32'd14);
    check_val("t1_hz", DW'({hazard1, hazard2}), '0);
    check_val("t1_err", DW'(sb_err), '0);
    tick();

    // Write/read latency
    drive(0, 0, 4'd0, 1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd0);
`ifdef REGFILE_BYPASS_EN
    check_val("t2_same", reg1, 32'hDEADBEEF);
`else
    check_val("t2_same", reg1, 32'd3);
`endif
    tick();
    idle(4'd3, 4'd0);
    check_val("t2_next", reg1, 32'hDEADBEEF);
    tick();

    // Scoreboard raise and clear
    drive(0, 1, 4'd7, 0, 4'd0, '0, 4'd7, 4'd0);
    check_val("t3_pre", DW'(hazard1), '0);
    tick();
    idle(4'd7, 4'd0);
    check_val("t3_raise", DW'(hazard1), 32'd1);
    tick();
    drive(0, 0, 4'd0, 1, 4'd7, 32'h77, 4'd7, 4'd0);
`ifdef REGFILE_BYPASS_EN
    check_val("t3_wb_cyc", DW'(hazard1), '0);
`else
    check_val("t3_wb_cyc", DW'(hazard1), 32'd1);
`endif
    tick();
    idle(4'd7, 4'd0);
    check_val("t3_clear", DW'(hazard1), '0);
    tick();

    // Saturation and overflow
    for (int k = 0; k < 3; k++) begin drive(0, 1, 4'd2, 0, 4'd0, '0, 4'd2, 4'd7); tick(); end
    drive(0, 1, 4'd2, 0, 4'd0, '0, 4'd2, 4'd7);
    check_val("t4_full", DW'(issue_full), 32'd1);
    tick();
    drive(0, 0, 4'd2, 0, 4'd0, '0, 4'd2, 4'd7);
    check_val("t4_err", DW'(sb_err), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 4'd0, 1, 4'd2, DW'(k), 4'd2, 4'd0);
      check_val("t4_still", DW'(hazard1), (k < 2) ? 32'd1 : DW'(0)
`ifndef REGFILE_BYPASS_EN
                | 32'd1
`endif
                );
      tick();
    end
    idle(4'd2, 4'd0);
    check_val("t4_clear", DW'(hazard1), '0);
    tick();

    // Reset beats a simultaneous write and issue
    drive(1, 1, 4'd9, 1, 4'd9, 32'hFF, 4'd9, 4'd0);
    tick();
    idle(4'd9, 4'd0);
    check_val("t6_reg", reg1, 32'd9);
    check_val("t6_hz", DW'(hazard1), '0);
    check_val("t6_err", DW'(sb_err), '0);
    tick();

    // Simultaneous issue and write-back on a register with one pending write
    drive(0, 1, 4'd4, 0, 4'd0, '0, 4'd4, 4'd0); tick();
    drive(0, 1, 4'd4, 1, 4'd4, 32'h1234, 4'd4, 4'd0); tick();
    idle(4'd4, 4'd0);
    check_val("t5_hz", DW'(hazard1), 32'd1);
    check_val("t5_reg", reg1, 32'h1234);
    tick();
    drive(0, 0, 4'd0, 1, 4'd4, 32'h5678, 4'd4, 4'd0); tick();
    idle(4'd4, 4'd0);
    check_val("t5_clear", DW'(hazard1), '0);
    check_val("t5_err", DW'(sb_err), '0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] dwb;
      dwb = ($urandom_range(0, 3) != 0) ? pick_pending() : AW'($urandom_range(0, NR-1));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 5)),
            ($urandom_range(0, 1) == 1), dwb, DW'($urandom),
            ($urandom_range(0, 1) == 1) ? dwb : AW'($urandom_range(0, NR-1)),
            AW'($urandom_range(0, 5)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
